// File: rtl/difftest_axis_packer_pkg.sv
// Shared types and elaboration-time helpers for the difftest AXI-Stream packer.
package difftest_axis_pkg;

    localparam int KEEP_MAX = 512;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int calc_beats(input int data_width, input int axis_width);
        return (data_width + axis_width - 1) / axis_width;
    endfunction

    // Byte-enable mask for the final (possibly partial) beat of a packet.
    function automatic logic [KEEP_MAX-1:0] calc_last_keep(input int data_width, input int axis_width);
        int last_bits;
        int last_bytes;
        logic [KEEP_MAX-1:0] keep;
        last_bits  = data_width - (calc_beats(data_width, axis_width) - 1) * axis_width;
        last_bytes = (last_bits + 7) / 8;
        keep       = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            keep[i] = (i < last_bytes);
        end
        return keep;
    endfunction

endpackage

// File: rtl/difftest_axis_packer_if.sv
// Core-side batch input, AXI-Stream output and profiling counters of the packer.
interface difftest_axis_packer_if #(
    parameter int DATA_WIDTH = 4096,
    parameter int AXIS_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0]   difftest_data;
    logic                    difftest_enable;
    logic                    core_clock_enable;
    logic [AXIS_WIDTH-1:0]   axi_tdata;
    logic [AXIS_WIDTH/8-1:0] axi_tkeep;
    logic                    axi_tlast;
    logic                    axi_tvalid;
    logic                    axi_tready;
    logic [CNT_WIDTH-1:0]    stall_cycles;
    logic [CNT_WIDTH-1:0]    pkt_sent;

    modport master (
        output difftest_data, difftest_enable, axi_tready,
        input  core_clock_enable, axi_tdata, axi_tkeep, axi_tlast, axi_tvalid,
        input  stall_cycles, pkt_sent
    );

    modport slave (
        input  difftest_data, difftest_enable, axi_tready,
        output core_clock_enable, axi_tdata, axi_tkeep, axi_tlast, axi_tvalid,
        output stall_cycles, pkt_sent
    );
endinterface

// File: rtl/difftest_axis_packer_fifo.sv
// Flop-based packet buffer; the head entry is always readable without a request.
module difftest_pkt_fifo #(
    parameter int DATA_WIDTH = 4096,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic [DATA_WIDTH-1:0]   head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [$clog2(DEPTH):0]  count_next_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed while the packer is sending.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;
endmodule

// File: rtl/difftest_axis_packer.sv
// Buffers wide difftest batches and serialises each into AXI-Stream beats,
// stalling the core through core_clock_enable instead of dropping packets.
module difftest_axis_packer
    import difftest_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 4096,
    parameter int AXIS_WIDTH = 512,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input logic                  clock,
    input logic                  reset,
    difftest_axis_packer_if.slave bus
);
    localparam int BEATS  = calc_beats(DATA_WIDTH, AXIS_WIDTH);
    localparam int KEEP_W = AXIS_WIDTH / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PAD_W  = BEATS * AXIS_WIDTH;
    localparam logic [KEEP_MAX-1:0] LAST_KEEP_ALL = calc_last_keep(DATA_WIDTH, AXIS_WIDTH);
    localparam logic [KEEP_W-1:0]   LAST_KEEP     = LAST_KEEP_ALL[KEEP_W-1:0];
    localparam logic [BEAT_W-1:0]   LAST_BEAT     = BEAT_W'(BEATS - 1);

    state_e                state_q;
    state_e                state_d;
    logic [BEAT_W-1:0]     beat_q;
    logic [BEAT_W-1:0]     beat_d;
    logic                  cce_q;
    logic [CNT_WIDTH-1:0]  stall_q;
    logic [CNT_WIDTH-1:0]  sent_q;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [CNT_W-1:0]      count_s;
    logic [CNT_W-1:0]      count_next_s;
    logic [PAD_W-1:0]      padded_s;
    logic                  tvalid_s;
    logic                  tlast_s;

    assign push_s = bus.difftest_enable & cce_q;

    difftest_pkt_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .wr_data_i   (bus.difftest_data),
        .head_o      (head_s),
        .count_o     (count_s),
        .count_next_o(count_next_s)
    );

    // Output FSM: beat sequencing, head pop on the tlast handshake.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_s != '0) begin
                    state_d = SEND;
                    beat_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bus.axi_tready) begin
                    if (beat_q != LAST_BEAT) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else begin
                        pop_s  = 1'b1;
                        beat_d = '0;
                        // count - 1 + push is nonzero iff another packet remains or arrives now
                        if ((count_s > CNT_W'(1)) || push_s) begin
                            state_d = SEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State, core enable and profiling counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cce_q   <= 1'b1;
            stall_q <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cce_q   <= (count_next_s != CNT_W'(DEPTH));
            if (!cce_q && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            if (pop_s) begin
                sent_q <= sent_q + CNT_WIDTH'(1);
            end
        end
    end

    // Beat slicing; data and keep read as zero whenever no beat is offered.
    always_comb begin
        padded_s                   = '0;
        padded_s[DATA_WIDTH-1:0]   = head_s;
        tvalid_s                   = (state_q == SEND);
        tlast_s                    = tvalid_s && (beat_q == LAST_BEAT);
        if (tvalid_s) begin
            bus.axi_tdata = padded_s[int'(beat_q) * AXIS_WIDTH +: AXIS_WIDTH];
            bus.axi_tkeep = tlast_s ? LAST_KEEP : '1;
        end else begin
            bus.axi_tdata = '0;
            bus.axi_tkeep = '0;
        end
    end

    assign bus.axi_tvalid        = tvalid_s;
    assign bus.axi_tlast         = tlast_s;
    assign bus.core_clock_enable = cce_q;
    assign bus.stall_cycles      = stall_q;
    assign bus.pkt_sent          = sent_q;
endmodule

// File: tb/tb_difftest_axis_packer.sv
// Scenario bench for difftest_axis_packer: a 3-beat config (1200/512, depth 2)
// and a single-beat config (512/512), checked against a packet-queue model.
module tb_difftest_axis_packer;
    localparam int DW   = 1200;
    localparam int AW   = 512;
    localparam int KW   = AW / 8;
    localparam int NB   = (DW + AW - 1) / AW;
    localparam int DEP  = 2;
    localparam int CW   = 32;
    localparam int DWB  = 512;
    localparam int LAST_BYTES = (DW - (NB - 1) * AW + 7) / 8;

    typedef struct packed {
        logic [AW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    difftest_axis_packer_if #(.DATA_WIDTH(DW),  .AXIS_WIDTH(AW), .CNT_WIDTH(CW)) ifa ();
    difftest_axis_packer_if #(.DATA_WIDTH(DWB), .AXIS_WIDTH(AW), .CNT_WIDTH(CW)) ifb ();

    difftest_axis_packer #(.DATA_WIDTH(DW), .AXIS_WIDTH(AW), .DEPTH(DEP), .CNT_WIDTH(CW)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa));
    difftest_axis_packer #(.DATA_WIDTH(DWB), .AXIS_WIDTH(AW), .DEPTH(4), .CNT_WIDTH(CW)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb));

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    beat_t exp_q[$];
    int    m_cnt;
    logic  m_cce;
    int    m_stall;
    int    m_sent;

    function automatic logic [DW-1:0] rand_pkt();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) v = {v[DW-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_cnt = 0; m_cce = 1'b1; m_stall = 0; m_sent = 0;
    endfunction

    // Expected beats of one accepted packet: low bytes first, padded with zeros.
    function automatic void model_push(logic [DW-1:0] d);
        logic [NB*AW-1:0] wide;
        beat_t b;
        wide = '0;
        wide[DW-1:0] = d;
        for (int k = 0; k < NB; k++) begin
            b.data = wide >> (k * AW);
            b.last = (k == NB - 1);
            b.keep = '1;
            if (b.last) begin
                b.keep = '0;
                for (int i = 0; i < LAST_BYTES; i++) b.keep[i] = 1'b1;
            end
            exp_q.push_back(b);
        end
    endfunction

    // One clock of dut_a: drive, observe at negedge, advance the model, return at posedge+1.
    task automatic step_a(input logic en, input logic [DW-1:0] d, input logic rdy,
                          output beat_t ob, output logic ov, output logic hs);
        ifa.difftest_enable = en;
        ifa.difftest_data   = d;
        ifa.axi_tready      = rdy;
        @(negedge clock);
        ob.data = ifa.axi_tdata;
        ob.keep = ifa.axi_tkeep;
        ob.last = ifa.axi_tlast;
        ov      = ifa.axi_tvalid;
        hs      = ifa.axi_tvalid && rdy;
        if (!m_cce) m_stall++;
        if (en && m_cce) begin model_push(d); m_cnt++; end
        if (hs && ob.last) begin m_cnt--; m_sent++; end
        @(posedge clock);
        #1;
        cyc++;
        m_cce = (m_cnt != DEP);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (ifa.axi_tvalid !== 1'b0 || ifa.axi_tlast !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_last: tvalid=%b tlast=%b, expected 0 0", ifa.axi_tvalid, ifa.axi_tlast);
        end
        n_checks++;
        if (ifa.axi_tdata !== '0 || ifa.axi_tkeep !== '0) begin
            n_fail++; $display("FAIL reset_data_keep: tdata=%h tkeep=%h, expected zero", ifa.axi_tdata, ifa.axi_tkeep);
        end
        n_checks++;
        if (ifa.core_clock_enable !== 1'b1 || ifb.core_clock_enable !== 1'b1) begin
            n_fail++; $display("FAIL reset_cce: a=%b b=%b, expected 1", ifa.core_clock_enable, ifb.core_clock_enable);
        end
        n_checks++;
        if (ifa.stall_cycles !== 32'd0 || ifa.pkt_sent !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: stall=%0d sent=%0d, expected 0 0", ifa.stall_cycles, ifa.pkt_sent);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_clear();
    endtask

    task automatic test_single_packet();
        beat_t ob, ex;
        logic  ov, hs;
        int    nhs = 0, first = -1, lastc = -1;
        step_a(1'b1, rand_pkt(), 1'b1, ob, ov, hs);
        for (int c = 0; c < 12 && nhs < 3; c++) begin
            step_a(1'b0, '0, 1'b1, ob, ov, hs);
            if (hs) begin
                nhs++;
                if (first < 0) first = cyc;
                lastc = cyc;
                n_checks++;
                ex = exp_q.pop_front();
                if (ob !== ex) begin
                    n_fail++; $display("FAIL single_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                                       nhs - 1, ob.data, ob.keep, ob.last, ex.data, ex.keep, ex.last);
                end
                n_checks++;
                if (nhs == 3 && (ob.keep !== 64'h3FFFFF || ob.last !== 1'b1 || ob.data[AW-1:176] !== '0)) begin
                    n_fail++; $display("FAIL single_last_beat: keep=%h last=%b upper=%h, expected 3fffff 1 0", ob.keep, ob.last, ob.data[AW-1:176]);
                end else if (nhs < 3 && (ob.keep !== 64'hFFFF_FFFF_FFFF_FFFF || ob.last !== 1'b0)) begin
                    n_fail++; $display("FAIL single_full_beat: keep=%h last=%b, expected all ones 0", ob.keep, ob.last);
                end
            end
        end
        n_checks++;
        if (nhs != 3 || lastc - first != 2) begin
            n_fail++; $display("FAIL single_timing: beats=%0d span=%0d, expected 3 beats over 2 cycles", nhs, lastc - first);
        end
        n_checks++;
        if (ifa.pkt_sent !== 32'd1) begin
            n_fail++; $display("FAIL single_pkt_sent: got %0d, expected 1", ifa.pkt_sent);
        end
    endtask

    task automatic test_backpressure();
        beat_t ob, ex;
        logic  ov, hs;
        int    nhs = 0, first = -1, lastc = -1;
        step_a(1'b1, rand_pkt(), 1'b0, ob, ov, hs);
        step_a(1'b1, rand_pkt(), 1'b0, ob, ov, hs);
        n_checks++;
        if (ifa.core_clock_enable !== 1'b0) begin
            n_fail++; $display("FAIL bp_cce_drop: got %b, expected 0", ifa.core_clock_enable);
        end
        step_a(1'b1, rand_pkt(), 1'b0, ob, ov, hs);
        repeat (2) step_a(1'b0, '0, 1'b0, ob, ov, hs);
        n_checks++;
        if (ifa.stall_cycles !== 32'd3) begin
            n_fail++; $display("FAIL bp_stall: got %0d, expected 3", ifa.stall_cycles);
        end
        for (int c = 0; c < 20 && nhs < 6; c++) begin
            step_a(1'b0, '0, 1'b1, ob, ov, hs);
            if (hs) begin
                nhs++;
                if (first < 0) first = cyc;
                lastc = cyc;
                n_checks++;
                ex = exp_q.pop_front();
                if (ob !== ex) begin
                    n_fail++; $display("FAIL bp_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                                       nhs - 1, ob.data, ob.keep, ob.last, ex.data, ex.keep, ex.last);
                end
                if (nhs == 3) begin
                    n_checks++;
                    if (ifa.core_clock_enable !== 1'b1) begin
                        n_fail++; $display("FAIL bp_cce_rise: got %b, expected 1", ifa.core_clock_enable);
                    end
                end
            end
        end
        n_checks++;
        if (nhs != 6 || lastc - first != 5) begin
            n_fail++; $display("FAIL bp_burst: beats=%0d span=%0d, expected 6 beats over 5 cycles", nhs, lastc - first);
        end
        nhs = 0;
        repeat (5) begin
            step_a(1'b0, '0, 1'b1, ob, ov, hs);
            if (hs) nhs++;
        end
        n_checks++;
        if (nhs != 0 || ifa.stall_cycles !== CW'(m_stall) || ifa.pkt_sent !== CW'(m_sent)) begin
            n_fail++; $display("FAIL bp_after: extra_beats=%0d stall=%0d sent=%0d, expected 0 %0d %0d",
                               nhs, ifa.stall_cycles, ifa.pkt_sent, m_stall, m_sent);
        end
    endtask

    task automatic test_full_simultaneous();
        beat_t ob, ex;
        logic  ov, hs, en, pushed = 1'b0;
        int    sent0 = m_sent;
        step_a(1'b1, rand_pkt(), 1'b1, ob, ov, hs);
        step_a(1'b1, rand_pkt(), 1'b1, ob, ov, hs);
        for (int c = 0; c < 30 && (exp_q.size() != 0 || !pushed); c++) begin
            en = !pushed && (m_sent == sent0 + 1) && ifa.axi_tvalid && ifa.axi_tlast;
            step_a(en, rand_pkt(), 1'b1, ob, ov, hs);
            if (en) begin
                pushed = 1'b1;
                n_checks++;
                if (ifa.core_clock_enable !== 1'b1) begin
                    n_fail++; $display("FAIL full_simul_cce: got %b, expected 1", ifa.core_clock_enable);
                end
            end
            if (hs) begin
                n_checks++;
                ex = exp_q.pop_front();
                if (ob !== ex) begin
                    n_fail++; $display("FAIL full_simul_beat: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                                       ob.data, ob.keep, ob.last, ex.data, ex.keep, ex.last);
                end
            end
        end
        n_checks++;
        if (!pushed || exp_q.size() != 0 || ifa.pkt_sent !== CW'(sent0 + 3)) begin
            n_fail++; $display("FAIL full_simul_drain: pushed=%b left=%0d sent=%0d, expected 1 0 %0d",
                               pushed, exp_q.size(), ifa.pkt_sent, sent0 + 3);
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t ob, ex;
        logic  ov, hs;
        int    nhs = 0;
        step_a(1'b1, rand_pkt(), 1'b1, ob, ov, hs);
        step_a(1'b1, rand_pkt(), 1'b1, ob, ov, hs);
        for (int c = 0; c < 10 && nhs == 0; c++) begin
            step_a(1'b0, '0, 1'b1, ob, ov, hs);
            if (hs) nhs++;
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ifa.axi_tvalid !== 1'b0 || ifa.core_clock_enable !== 1'b1 || nhs != 1) begin
            n_fail++; $display("FAIL midreset_outputs: tvalid=%b cce=%b beat0_seen=%0d, expected 0 1 1",
                               ifa.axi_tvalid, ifa.core_clock_enable, nhs);
        end
        n_checks++;
        if (ifa.stall_cycles !== 32'd0 || ifa.pkt_sent !== 32'd0) begin
            n_fail++; $display("FAIL midreset_counters: stall=%0d sent=%0d, expected 0 0", ifa.stall_cycles, ifa.pkt_sent);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_clear();
        nhs = 0;
        repeat (4) begin
            step_a(1'b0, '0, 1'b1, ob, ov, hs);
            if (ov) nhs++;
        end
        n_checks++;
        if (nhs != 0) begin
            n_fail++; $display("FAIL midreset_empty: %0d valid cycles after reset, expected 0", nhs);
        end
        step_a(1'b1, rand_pkt(), 1'b1, ob, ov, hs);
        for (int c = 0; c < 12 && nhs < 3; c++) begin
            step_a(1'b0, '0, 1'b1, ob, ov, hs);
            if (hs) begin
                nhs++;
                n_checks++;
                ex = exp_q.pop_front();
                if (ob !== ex) begin
                    n_fail++; $display("FAIL midreset_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                                       nhs - 1, ob.data, ob.keep, ob.last, ex.data, ex.keep, ex.last);
                end
            end
        end
        n_checks++;
        if (nhs != 3 || ifa.pkt_sent !== 32'd1) begin
            n_fail++; $display("FAIL midreset_next_pkt: beats=%0d sent=%0d, expected 3 1", nhs, ifa.pkt_sent);
        end
    endtask

    task automatic test_random();
        beat_t         ob, ex, hold_b;
        logic          ov, hs, rdy, en, hold = 1'b0;
        logic [DW-1:0] pkt = rand_pkt();
        int            acc = 0, bad_stable = 0, bad_data = 0;
        int            sent0 = m_sent;
        for (int c = 0; c < 4000 && (acc < 100 || exp_q.size() != 0); c++) begin
            rdy = 1'($urandom_range(1, 0));
            en  = (acc < 100) && ($urandom_range(3, 0) != 0);
            if (en && m_cce) begin
                step_a(1'b1, pkt, rdy, ob, ov, hs);
                acc++;
                pkt = rand_pkt();
            end else begin
                step_a(en, pkt, rdy, ob, ov, hs);
            end
            if (hold && (!ov || ob !== hold_b)) bad_stable++;
            hold   = ov && !rdy;
            hold_b = ob;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    bad_data++;
                end else begin
                    ex = exp_q.pop_front();
                    if (ob !== ex) bad_data++;
                end
            end
        end
        n_checks++;
        if (bad_stable != 0) begin
            n_fail++; $display("FAIL random_stable: %0d unstable stalled beats, expected 0", bad_stable);
        end
        n_checks++;
        if (bad_data != 0 || acc != 100 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_stream: bad_beats=%0d accepted=%0d left=%0d, expected 0 100 0",
                               bad_data, acc, exp_q.size());
        end
        n_checks++;
        if (ifa.pkt_sent !== CW'(sent0 + 100) || ifa.stall_cycles !== CW'(m_stall)) begin
            n_fail++; $display("FAIL random_counters: sent=%0d stall=%0d, expected %0d %0d",
                               ifa.pkt_sent, ifa.stall_cycles, sent0 + 100, m_stall);
        end
    endtask

    task automatic test_single_beat_config();
        logic [DWB-1:0] q[$];
        logic [DWB-1:0] d, ex;
        int             bad = 0, seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) begin
                for (int i = 0; i < DWB / 32; i++) d = {d[DWB-33:0], 32'($urandom)};
                ifb.difftest_data   = d;
                ifb.difftest_enable = 1'b1;
                q.push_back(d);
            end else begin
                ifb.difftest_enable = 1'b0;
            end
            ifb.axi_tready = 1'b1;
            @(negedge clock);
            if (ifb.axi_tvalid) begin
                seen++;
                ex = (q.size() != 0) ? q.pop_front() : '0;
                if (ifb.axi_tdata !== ex || ifb.axi_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF || ifb.axi_tlast !== 1'b1) bad++;
            end
            if (ifb.core_clock_enable !== 1'b1) bad++;
            @(posedge clock);
            #1;
        end
        n_checks++;
        if (bad != 0 || seen != 6) begin
            n_fail++; $display("FAIL one_beat_stream: bad=%0d beats=%0d, expected 0 6", bad, seen);
        end
        n_checks++;
        if (ifb.pkt_sent !== 32'd6) begin
            n_fail++; $display("FAIL one_beat_pkt_sent: got %0d, expected 6", ifb.pkt_sent);
        end
    endtask

    initial begin
        ifa.difftest_enable = 1'b0; ifa.difftest_data = '0; ifa.axi_tready = 1'b0;
        ifb.difftest_enable = 1'b0; ifb.difftest_data = '0; ifb.axi_tready = 1'b0;
        model_clear();
        test_reset();
        test_single_packet();
        test_backpressure();
        test_full_simultaneous();
        test_reset_mid_packet();
        test_random();
        test_single_beat_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
